// File: rtl/car_types_pkg.sv
// Shared light/phase encodings and default lane and timing constants for the crossroad controllers.
package car_types_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } strafic_light_t;

  typedef enum logic [2:0] {
    ALL_RED_BA = 3'd0,
    A_GREEN    = 3'd1,
    A_YELLOW   = 3'd2,
    ALL_RED_AB = 3'd3,
    B_GREEN    = 3'd4,
    B_YELLOW   = 3'd5
  } crossroad_status_t;

  localparam int DEF_NUM_LANES       = 2;
  localparam int DEF_MAX_CARS        = 15;
  localparam int DEF_GREEN_TICKS     = 8;
  localparam int DEF_YELLOW_TICKS    = 2;
  localparam int DEF_ALL_RED_TICKS   = 1;
  localparam int DEF_MIN_GREEN_TICKS = 3;

  function automatic crossroad_status_t next_phase(input crossroad_status_t s);
    case (s)
      ALL_RED_BA: next_phase = A_GREEN;
      A_GREEN:    next_phase = A_YELLOW;
      A_YELLOW:   next_phase = ALL_RED_AB;
      ALL_RED_AB: next_phase = B_GREEN;
      B_GREEN:    next_phase = B_YELLOW;
      default:    next_phase = ALL_RED_BA;
    endcase
  endfunction

endpackage

// File: rtl/lane_queue_counter.sv
// One lane's car queue: rising-edge detect on arrivals, saturating up/down count, sticky overflow.
module lane_queue_counter #(
  parameter int MAX_CARS = 15
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              arrive_i,
  input  logic                              depart_i,
  output logic [$clog2(MAX_CARS+1)-1:0]     count_o,
  output logic                              overflow_o
);

  localparam int CNT_W = $clog2(MAX_CARS + 1);

  logic             arr_q, arr_prev_q;
  logic             arr_edge;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  assign arr_edge = arr_q & ~arr_prev_q;

  // A simultaneous arrival and departure cancel, so saturation and overflow never trigger on them.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (arr_edge && !depart_i) begin
      if (cnt_q == CNT_W'(MAX_CARS)) ovf_d = 1'b1;
      else                           cnt_d = cnt_q + CNT_W'(1);
    end else if (depart_i && !arr_edge && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arr_q      <= 1'b0;
      arr_prev_q <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      arr_q      <= arrive_i;
      arr_prev_q <= arr_q;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/car_crossroad_multilane.sv
// Two-approach, multi-lane crossroad: tick-timed phase FSM, registered lights, per-lane queues.
// Define CROSSROAD_SKIP_IDLE_EN to cut an idle green short once MIN_GREEN_TICKS have elapsed.
//
// state      | meaning
// ALL_RED_BA | clearance after B, reset state
// A_GREEN    | A flows, departures drain A lanes
// A_YELLOW   | A stopping
// ALL_RED_AB | clearance after A
// B_GREEN    | B flows, departures drain B lanes
// B_YELLOW   | B stopping
module car_crossroad_multilane
  import car_types_pkg::*;
#(
  parameter int NUM_LANES       = DEF_NUM_LANES,
  parameter int MAX_CARS        = DEF_MAX_CARS,
  parameter int GREEN_TICKS     = DEF_GREEN_TICKS,
  parameter int YELLOW_TICKS    = DEF_YELLOW_TICKS,
  parameter int ALL_RED_TICKS   = DEF_ALL_RED_TICKS,
  parameter int MIN_GREEN_TICKS = DEF_MIN_GREEN_TICKS
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      tick_in,
  input  logic                                      depart_in,
  input  logic [NUM_LANES-1:0]                      arrive_a_in,
  input  logic [NUM_LANES-1:0]                      arrive_b_in,
  output strafic_light_t                            light_a,
  output strafic_light_t                            light_b,
  output crossroad_status_t                         status,
  output logic [NUM_LANES*$clog2(MAX_CARS+1)-1:0]   count_a,
  output logic [NUM_LANES*$clog2(MAX_CARS+1)-1:0]   count_b,
  output logic [NUM_LANES-1:0]                      overflow_a,
  output logic [NUM_LANES-1:0]                      overflow_b
);

  localparam int CNT_W   = $clog2(MAX_CARS + 1);
  localparam int MAX_GY  = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int MAX_RM  = (ALL_RED_TICKS > MIN_GREEN_TICKS) ? ALL_RED_TICKS : MIN_GREEN_TICKS;
  localparam int MAX_DUR = (MAX_GY > MAX_RM) ? MAX_GY : MAX_RM;
  localparam int TMR_W   = $clog2(MAX_DUR + 1);

  crossroad_status_t state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  strafic_light_t    light_a_q, light_a_d, light_b_q, light_b_d;
  logic              dep_q, dep_prev_q;
  logic              dep_a, dep_b;
  logic              skip;

  function automatic logic [TMR_W-1:0] phase_last(input crossroad_status_t s);
    case (s)
      A_GREEN, B_GREEN:   phase_last = TMR_W'(GREEN_TICKS - 1);
      A_YELLOW, B_YELLOW: phase_last = TMR_W'(YELLOW_TICKS - 1);
      default:            phase_last = TMR_W'(ALL_RED_TICKS - 1);
    endcase
  endfunction

`ifdef CROSSROAD_SKIP_IDLE_EN
  logic a_idle, b_idle;
  assign a_idle = ~|count_a;
  assign b_idle = ~|count_b;
  assign skip   = ((state_q == A_GREEN && a_idle && !b_idle) ||
                   (state_q == B_GREEN && b_idle && !a_idle)) &&
                  (timer_q >= TMR_W'(MIN_GREEN_TICKS - 1));
`else
  assign skip = 1'b0;
`endif

  // Lights decode the next state so they change in the same cycle as status.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    light_a_d = RED;
    light_b_d = RED;
    if (tick_in) begin
      if (timer_q == phase_last(state_q) || skip) begin
        state_d = next_phase(state_q);
        timer_d = '0;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end
    case (state_d)
      A_GREEN:  light_a_d = GREEN;
      A_YELLOW: light_a_d = YELLOW;
      B_GREEN:  light_b_d = GREEN;
      B_YELLOW: light_b_d = YELLOW;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ALL_RED_BA;
      timer_q    <= '0;
      light_a_q  <= RED;
      light_b_q  <= RED;
      dep_q      <= 1'b0;
      dep_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      light_a_q  <= light_a_d;
      light_b_q  <= light_b_d;
      dep_q      <= depart_in;
      dep_prev_q <= dep_q;
    end
  end

  assign dep_a = dep_q && !dep_prev_q && (state_q == A_GREEN);
  assign dep_b = dep_q && !dep_prev_q && (state_q == B_GREEN);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_queue_counter #(.MAX_CARS(MAX_CARS)) u_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .arrive_i   (arrive_a_in[i]),
      .depart_i   (dep_a),
      .count_o    (count_a[i*CNT_W +: CNT_W]),
      .overflow_o (overflow_a[i])
    );
    lane_queue_counter #(.MAX_CARS(MAX_CARS)) u_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .arrive_i   (arrive_b_in[i]),
      .depart_i   (dep_b),
      .count_o    (count_b[i*CNT_W +: CNT_W]),
      .overflow_o (overflow_b[i])
    );
  end

  assign status  = state_q;
  assign light_a = light_a_q;
  assign light_b = light_b_q;

endmodule

// File: tb/tb_car_crossroad_multilane.sv
// Directed bench for car_crossroad_multilane; expectations queued at stimulus, popped at observation.
module tb_car_crossroad_multilane;
  import car_types_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n, tick_in, depart_in;
  logic [1:0]        arrive_a_in, arrive_b_in;
  strafic_light_t    light_a, light_b;
  crossroad_status_t status;
  logic [7:0]        count_a, count_b;
  logic [1:0]        overflow_a, overflow_b;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  car_crossroad_multilane dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_in     (tick_in),
    .depart_in   (depart_in),
    .arrive_a_in (arrive_a_in),
    .arrive_b_in (arrive_b_in),
    .light_a     (light_a),
    .light_b     (light_b),
    .status      (status),
    .count_a     (count_a),
    .count_b     (count_b),
    .overflow_a  (overflow_a),
    .overflow_b  (overflow_b)
  );

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    string       tag;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h expected nothing queued", obs);
    end else begin
      tag = tag_q.pop_front();
      e   = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic push_phase(input string tag, input crossroad_status_t st,
                            input strafic_light_t la, input strafic_light_t lb);
    push({tag, "_status"}, 32'(st));
    push({tag, "_lights"}, {28'd0, la, lb});
  endtask

  task automatic chk_phase();
    pop_chk(32'(status));
    pop_chk({28'd0, light_a, light_b});
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic d);
    arrive_a_in = a;
    arrive_b_in = b;
    depart_in   = d;
    repeat (2) @(negedge clk);
    arrive_a_in = 2'b00;
    arrive_b_in = 2'b00;
    depart_in   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; tick_in = 1'b0; depart_in = 1'b0;
    arrive_a_in = 2'b00; arrive_b_in = 2'b00;

    // reset
    push_phase("reset", ALL_RED_BA, RED, RED);
    push("reset_count_a", 32'd0);
    push("reset_count_b", 32'd0);
    push("reset_overflow", 32'd0);
    repeat (3) @(negedge clk);
    chk_phase();
    pop_chk(32'(count_a));
    pop_chk(32'(count_b));
    pop_chk(32'({overflow_a, overflow_b}));
    rst_n = 1'b1;
    @(negedge clk);

    // phase walk
    push_phase("walk_a_green", A_GREEN, GREEN, RED);      ticks(1); chk_phase();
    push_phase("walk_a_green_t7", A_GREEN, GREEN, RED);   ticks(7); chk_phase();
    push_phase("walk_a_yellow", A_YELLOW, YELLOW, RED);   ticks(1); chk_phase();
    push_phase("walk_all_red_ab", ALL_RED_AB, RED, RED);  ticks(2); chk_phase();
    push_phase("walk_b_green", B_GREEN, RED, GREEN);      ticks(1); chk_phase();
    push_phase("walk_b_yellow", B_YELLOW, RED, YELLOW);   ticks(8); chk_phase();
    push_phase("walk_all_red_ba", ALL_RED_BA, RED, RED);  ticks(2); chk_phase();

    // queue arrivals and departures
    push_phase("q_a_green", A_GREEN, GREEN, RED);         ticks(1); chk_phase();
    push("q_arrive_twice", 32'd2);
    drive(2'b01, 2'b00, 1'b0);
    drive(2'b01, 2'b00, 1'b0);
    pop_chk(32'(count_a[3:0]));
    push("q_depart_green", 32'd1);
    drive(2'b00, 2'b00, 1'b1);
    pop_chk(32'(count_a[3:0]));
    push_phase("q_a_yellow", A_YELLOW, YELLOW, RED);      ticks(8); chk_phase();
    push("q_depart_yellow", 32'd1);
    drive(2'b00, 2'b00, 1'b1);
    pop_chk(32'(count_a[3:0]));

    // saturation on B lane 1
    push("sat_count_15", 32'd15);
    push("sat_no_ovf_yet", 32'd0);
    repeat (15) drive(2'b00, 2'b10, 1'b0);
    pop_chk(32'(count_b[7:4]));
    pop_chk(32'(overflow_b));
    push("sat_count_hold", 32'd15);
    push("sat_ovf_set", 32'b10);
    drive(2'b00, 2'b10, 1'b0);
    pop_chk(32'(count_b[7:4]));
    pop_chk(32'(overflow_b));

    // simultaneous arrive + depart
    push_phase("sim_a_green", A_GREEN, GREEN, RED);       ticks(14); chk_phase();
    push("sim_lane0_pre", 32'd3);
    drive(2'b01, 2'b00, 1'b0);
    drive(2'b01, 2'b00, 1'b0);
    pop_chk(32'(count_a[3:0]));
    push("sim_lane0_hold", 32'd3);
    push("sim_lane1_zero", 32'd0);
    drive(2'b11, 2'b00, 1'b1);
    pop_chk(32'(count_a[3:0]));
    pop_chk(32'(count_a[7:4]));

    // idle green with a waiting B car
    push("idle_a_empty", 32'd0);
    repeat (3) drive(2'b00, 2'b00, 1'b1);
    pop_chk(32'(count_a));
    push("idle_b_lane0", 32'd1);
    drive(2'b00, 2'b01, 1'b0);
    pop_chk(32'(count_b[3:0]));
    push_phase("idle_t2", A_GREEN, GREEN, RED);           ticks(2); chk_phase();
`ifdef CROSSROAD_SKIP_IDLE_EN
    push_phase("idle_skip_t3", A_YELLOW, YELLOW, RED);    ticks(1); chk_phase();
`else
    push_phase("idle_t3", A_GREEN, GREEN, RED);           ticks(1); chk_phase();
    push_phase("idle_t7", A_GREEN, GREEN, RED);           ticks(4); chk_phase();
    push_phase("idle_t8", A_YELLOW, YELLOW, RED);         ticks(1); chk_phase();
`endif

    // reset in the middle of B_GREEN
    push_phase("mid_b_green", B_GREEN, RED, GREEN);       ticks(3); chk_phase();
    push_phase("mid_b_green_t2", B_GREEN, RED, GREEN);    ticks(2); chk_phase();
    push_phase("mid_reset", ALL_RED_BA, RED, RED);
    push("mid_reset_count_a", 32'd0);
    push("mid_reset_count_b", 32'd0);
    push("mid_reset_overflow", 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_phase();
    pop_chk(32'(count_a));
    pop_chk(32'(count_b));
    pop_chk(32'({overflow_a, overflow_b}));
    rst_n = 1'b1;
    @(negedge clk);
    push_phase("post_a_green", A_GREEN, GREEN, RED);      ticks(1); chk_phase();
    push_phase("post_a_green_t7", A_GREEN, GREEN, RED);   ticks(7); chk_phase();
    push_phase("post_a_yellow", A_YELLOW, YELLOW, RED);   ticks(1); chk_phase();

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
